mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised memory-stage load/store unit for the RISC-V pipeline. It sits between the execute-stage outputs and a handshaked data memory, replacing fixed-latency memory access with a req/gnt/rvalid protocol. It generates byte enables and shifted store data, masks and sign-extends load data, detects misalignment and stalls the pipeline while an access is outstanding.

Parameters:
N, 64, datapath and address width; legal values 32 or 64.
TIMEOUT_CYCLES, 255, watchdog limit in cycles. Used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
memRead_E  in  1  load request from execute
memWrite_E  in  1  store request from execute
memWidth  in  3  000 byte, 001 half, 010 word, 011 dword; 1xx reserved
signedRead  in  1  sign-extend load result
addr_E  in  N  byte address
writeData_E  in  N  store data, LSB-aligned
flush  in  1  kill current or pending access
dm_req  out  1  memory request valid
dm_we  out  1  1 = write
dm_addr  out  N  address aligned to N/8 bytes (low log2(N/8) bits = 0)
dm_wdata  out  N  store data shifted to lane
dm_be  out  N/8  byte enables
dm_gnt  in  1  memory accepts request
dm_rvalid  in  1  read data valid
dm_rdata  in  N  read data, full word
stall_M  out  1  hold upstream pipeline
readDataMasked_M  out  N  masked load result
loadValid_M  out  1  one-cycle pulse, readDataMasked_M valid
misaligned_M  out  1  one-cycle pulse, misaligned or illegal access
busError_M  out  1  one-cycle pulse, watchdog expiry

Behaviour:
- Reset: state IDLE; all outputs 0; internal latches and kill flag cleared. Reset mid-access abandons it; any later dm_rvalid is ignored while IDLE.
- Byte offset: off = addr_E[log2(N/8)-1:0].
- Misalignment: half needs off[0]=0, word needs off[1:0]=0, dword needs off[2:0]=0.
- Illegal access: dword when N=32, or memWidth=1xx.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE transitions:
  - A valid op is memRead_E or memWrite_E, with memWrite_E taking priority if both are set.
  - Valid op, aligned, no flush: latch we, addr, width, signedRead, off, wdata and be. Go to REQ.
  - Misaligned or illegal op: misaligned_M=1 in the next cycle. No request, no stall, stay IDLE.
  - flush in IDLE: no start.
- stall_M is combinational: 1 when (IDLE and start) or state is REQ or RSP. It is 0 in DONE and IDLE otherwise.
- REQ:
  - dm_req=1; dm_we, dm_addr, dm_wdata and dm_be are driven from the latches and held stable until dm_gnt.
  - On dm_gnt: a store goes to DONE; a load goes to RSP.
  - flush before dm_gnt: drop dm_req and go to DONE with no loadValid_M.
- RSP:
  - Wait for dm_rvalid; dm_rvalid outside RSP is ignored.
  - flush in RSP sets the kill flag. The state still waits for dm_rvalid, because the response is outstanding.
  - On dm_rvalid: register the result. Assert loadValid_M in the next cycle unless killed. Go to DONE.
- DONE: one cycle, no stall, no new start accepted. The upstream advances on this edge; next state is IDLE. Back-to-back memory ops therefore incur one bubble.
- Store lane formation: be = widthmask << off, where widthmask is 1, 3, F or FF. wdata = writeData_E << (8*off).
- Load result formation: s = dm_rdata >> (8*off). Keep the low 8/16/32/N bits; zero- or sign-extend per signedRead. readDataMasked_M holds its value until the next load completes.
- Minimum load latency: op accepted at T0, dm_req at T1, dm_gnt at T1, dm_rvalid at T2, loadValid_M and DONE at T3.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter clears on REQ entry and increments each cycle in REQ or RSP.
  - When it reaches TIMEOUT_CYCLES: deassert dm_req, pulse busError_M in the next cycle, suppress loadValid_M and go to DONE.
  - A dm_rvalid arriving later is ignored.
- Undefined: no counter; busError_M is tied to 0; the unit waits indefinitely.

Test Plan:
- N=64, LW signed, addr=0x1004, dm_rdata=0x80000000_00000000, gnt at T1, rvalid at T2 -> dm_addr=0x1000; readDataMasked_M=0xFFFFFFFF_80000000; loadValid_M at T3; stall_M high for T0-T2.
- SB addr=0x2003, writeData_E=0xAB -> dm_be=0x08, dm_wdata=0x00000000_AB000000, dm_we=1; DONE the cycle after gnt.
- LH addr=0x11 -> misaligned_M=1 next cycle, dm_req stays 0, stall_M=0. LD with N=32 -> misaligned_M=1.
- LBU addr=0x7, with dm_gnt held low for 5 cycles -> dm_req and dm_addr stable for 5 cycles; result 0x00..00FF from dm_rdata=0xFF00..., no sign extension.
- Load with flush during RSP, dm_rvalid 3 cycles later -> no loadValid_M, FSM passes through DONE to IDLE. Reset asserted in REQ -> dm_req=0 next cycle.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no dm_gnt -> busError_M pulse, then IDLE. Without the macro -> busError_M is always 0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit for the RISC-V pipeline.
// Connects execute-stage load/store requests to a req/gnt/rvalid data
// memory. It forms byte enables and lane-shifted store data, aligns and
// extends load data, flags misaligned or illegal accesses, and stalls the
// pipeline while an access is outstanding.
// Optional feature: define LSU_TIMEOUT_EN to enable a watchdog that abandons
// an access after TIMEOUT_CYCLES cycles in REQ/RSP and pulses busError_M.
module mem_stage_lsu #(
  parameter int N              = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           memRead_E,
  input  logic           memWrite_E,
  input  logic [2:0]     memWidth,
  input  logic           signedRead,
  input  logic [N-1:0]   addr_E,
  input  logic [N-1:0]   writeData_E,
  input  logic           flush,
  output logic           dm_req,
  output logic           dm_we,
  output logic [N-1:0]   dm_addr,
  output logic [N-1:0]   dm_wdata,
  output logic [N/8-1:0] dm_be,
  input  logic           dm_gnt,
  input  logic           dm_rvalid,
  input  logic [N-1:0]   dm_rdata,
  output logic           stall_M,
  output logic [N-1:0]   readDataMasked_M,
  output logic           loadValid_M,
  output logic           misaligned_M,
  output logic           busError_M
);

  localparam int BEW  = N / 8;
  localparam int OFFW = $clog2(BEW);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t          state;

  // Decoded view of the execute-stage request
  logic            op_valid;
  logic            op_bad;
  logic            illegal;
  logic            start;
  logic [OFFW-1:0] off;
  logic [2:0]      amask;
  logic [7:0]      wmask8;
  logic [BEW-1:0]  op_be;
  logic [N-1:0]    op_wdata;
  logic [N-1:0]    op_addr;

  // Latched access attributes needed when the load data returns
  logic [1:0]      width_q;
  logic            signed_q;
  logic [OFFW-1:0] off_q;
  logic            kill_q;

  // Load data alignment and extension
  logic [N-1:0]    shifted;
  logic [N-1:0]    load_val;

  // Watchdog expiry for the current cycle (constant 0 without the watchdog)
  logic            tmo_hit;

  // Decode width, alignment and lane placement of the incoming request
  always_comb begin
    // NOTE: every signal gets a value on every path through this block so no latch is inferred.
    op_valid = memRead_E | memWrite_E;
    off      = addr_E[OFFW-1:0];
    case (memWidth[1:0])
      2'b00:   begin amask = 3'd0; wmask8 = 8'h01; end
      2'b01:   begin amask = 3'd1; wmask8 = 8'h03; end
      2'b10:   begin amask = 3'd3; wmask8 = 8'h0F; end
      default: begin amask = 3'd7; wmask8 = 8'hFF; end
    endcase
    illegal  = memWidth[2] | ((memWidth[1:0] == 2'b11) && (N == 32));
    op_bad   = illegal | ((off & OFFW'(amask)) != '0);
    op_be    = BEW'(wmask8) << off;
    op_wdata = writeData_E << {off, 3'b000};
    op_addr  = {addr_E[N-1:OFFW], {OFFW{1'b0}}};
    start    = !reset && (state == IDLE) && op_valid && !op_bad && !flush;
  end

  // Shift the returned word down to the accessed bytes, then extend
  always_comb begin
    shifted = dm_rdata >> {off_q, 3'b000};
    case (width_q)
      2'b00:   load_val = signed_q ? N'(signed'(shifted[7:0]))  : N'(shifted[7:0]);
      2'b01:   load_val = signed_q ? N'(signed'(shifted[15:0])) : N'(shifted[15:0]);
      2'b10:   load_val = signed_q ? N'(signed'(shifted[31:0])) : N'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  // NOTE: stall_M is combinational so the pipeline holds in the same cycle the access is accepted.
  assign stall_M = start | (state == REQ) | (state == RSP);

  // Access FSM with registered memory-side and result outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state            <= IDLE;
      dm_req           <= 1'b0;
      dm_we            <= 1'b0;
      dm_addr          <= '0;
      dm_wdata         <= '0;
      dm_be            <= '0;
      width_q          <= '0;
      signed_q         <= 1'b0;
      off_q            <= '0;
      kill_q           <= 1'b0;
      readDataMasked_M <= '0;
      loadValid_M      <= 1'b0;
      misaligned_M     <= 1'b0;
    end else begin
      loadValid_M  <= 1'b0;
      misaligned_M <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dm_req   <= 1'b1;
            dm_we    <= memWrite_E;
            dm_addr  <= op_addr;
            dm_wdata <= op_wdata;
            dm_be    <= op_be;
            width_q  <= memWidth[1:0];
            signed_q <= signedRead;
            off_q    <= off;
            kill_q   <= 1'b0;
            state    <= REQ;
          end else if (op_valid && op_bad && !flush) begin
            misaligned_M <= 1'b1;
          end
        end
        REQ: begin
          // A grant means the memory has taken the access, so it wins over flush
          if (dm_gnt) begin
            dm_req <= 1'b0;
            if (dm_we) begin
              state <= DONE;
            end else begin
              kill_q <= flush;
              state  <= RSP;
            end
          end else if (flush || tmo_hit) begin
            dm_req <= 1'b0;
            state  <= DONE;
          end
        end
        RSP: begin
          if (dm_rvalid) begin
            if (!(kill_q || flush)) begin
              readDataMasked_M <= load_val;
              loadValid_M      <= 1'b1;
            end
            state <= DONE;
          end else if (tmo_hit) begin
            state <= DONE;
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          kill_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Expiry when this cycle would bring the count to the limit with no progress
  assign tmo_hit = ((state == REQ && !dm_gnt) || (state == RSP && !dm_rvalid)) &&
                   ((tmo_cnt + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Watchdog counter and bus-error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt    <= '0;
      busError_M <= 1'b0;
    end else begin
      busError_M <= tmo_hit;
      if (start) begin
        tmo_cnt <= '0;
      end else if (state == REQ || state == RSP) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign busError_M = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench for mem_stage_lsu.
// A transaction-level model scripts each access cycle by cycle and sets the
// expected outputs; one compare process checks the DUT on every falling edge.
module tb_mem_stage_lsu;

  localparam int N   = 64;
  localparam int BEW = N / 8;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif

  localparam int F_NONE = 0;
  localparam int F_IDLE = 1;
  localparam int F_REQ  = 2;
  localparam int F_RSP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           memRead_E, memWrite_E, signedRead, flush, dm_gnt, dm_rvalid;
  logic [2:0]     memWidth;
  logic [N-1:0]   addr_E, writeData_E, dm_rdata;
  logic           dm_req, dm_we, stall_M, loadValid_M, misaligned_M, busError_M;
  logic [N-1:0]   dm_addr, dm_wdata, readDataMasked_M;
  logic [BEW-1:0] dm_be;

  // Second instance for the 32-bit datapath
  logic        m32_read = 0, m32_write = 0, m32_signed = 0, m32_flush = 0;
  logic        m32_gnt = 0, m32_rvalid = 0;
  logic [2:0]  m32_width = 0;
  logic [31:0] m32_addr = 0, m32_wdata = 0, m32_rdata = 0;
  logic        o32_req, o32_we, o32_stall, o32_lv, o32_mis, o32_berr;
  logic [31:0] o32_addr, o32_wdata, o32_rd;
  logic [3:0]  o32_be;

  mem_stage_lsu #(.N(N), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .memWidth(memWidth), .signedRead(signedRead), .addr_E(addr_E),
    .writeData_E(writeData_E), .flush(flush), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .stall_M(stall_M),
    .readDataMasked_M(readDataMasked_M), .loadValid_M(loadValid_M),
    .misaligned_M(misaligned_M), .busError_M(busError_M)
  );

  mem_stage_lsu #(.N(32)) u_dut32 (
    .clk(clk), .reset(reset), .memRead_E(m32_read), .memWrite_E(m32_write),
    .memWidth(m32_width), .signedRead(m32_signed), .addr_E(m32_addr),
    .writeData_E(m32_wdata), .flush(m32_flush), .dm_req(o32_req), .dm_we(o32_we),
    .dm_addr(o32_addr), .dm_wdata(o32_wdata), .dm_be(o32_be), .dm_gnt(m32_gnt),
    .dm_rvalid(m32_rvalid), .dm_rdata(m32_rdata), .stall_M(o32_stall),
    .readDataMasked_M(o32_rd), .loadValid_M(o32_lv),
    .misaligned_M(o32_mis), .busError_M(o32_berr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic bit m_bad(input logic [2:0] w, input logic [N-1:0] a, input int n);
    int size;
    if (w[2]) return 1'b1;
    if (n == 32 && w == 3'd3) return 1'b1;
    size = 1 << w;
    return (a % size) != 0;
  endfunction

  function automatic int m_off(input logic [N-1:0] a);
    return int'(a % BEW);
  endfunction

  function automatic logic [BEW-1:0] m_be(input logic [2:0] w, input int off);
    int wm;
    wm = (1 << (1 << w)) - 1;
    return BEW'(wm << off);
  endfunction

  function automatic logic [N-1:0] m_wdata(input logic [N-1:0] wd, input int off);
    logic [127:0] v;
    v = 128'(wd) << (8 * off);
    return v[N-1:0];
  endfunction

  function automatic logic [N-1:0] m_load(input logic [N-1:0] rdat, input logic [2:0] w,
                                          input int off, input bit sg);
    logic [127:0] s, mask;
    int bits;
    bits = 8 << w;
    s    = 128'(rdat) >> (8 * off);
    mask = (128'd1 << bits) - 128'd1;
    s    = s & mask;
    if (sg && s[bits-1]) s = s | ~mask;
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- expectations for the current cycle ----------------
  bit             chk_en = 1'b0;
  logic           exp_stall = 0, exp_req = 0, exp_we = 0;
  logic           exp_lv = 0, exp_mis = 0, exp_berr = 0;
  logic           nxt_lv = 0, nxt_mis = 0, nxt_berr = 0;
  logic [N-1:0]   exp_addr = 0, exp_wdata = 0, exp_rd = 0;
  logic [BEW-1:0] exp_be = 0;

  // Compare the DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_M", stall_M, exp_stall);
      check("dm_req", dm_req, exp_req);
      if (exp_req) begin
        check("dm_we", dm_we, exp_we);
        check("dm_addr", dm_addr, exp_addr);
        check("dm_be", dm_be, exp_be);
        if (exp_we) check("dm_wdata", dm_wdata, exp_wdata);
      end
      check("loadValid_M", loadValid_M, exp_lv);
      if (exp_lv) check("readDataMasked_M", readDataMasked_M, exp_rd);
      check("misaligned_M", misaligned_M, exp_mis);
      check("busError_M", busError_M, exp_berr);
    end
  end

  // Advance one cycle: move pending pulses into view, idle the inputs
  task automatic tick();
    @(posedge clk);
    #1;
    exp_lv   = nxt_lv;   nxt_lv   = 1'b0;
    exp_mis  = nxt_mis;  nxt_mis  = 1'b0;
    exp_berr = nxt_berr; nxt_berr = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    memRead_E   = 1'b0;
    memWrite_E  = 1'b0;
    flush       = 1'b0;
    dm_gnt      = 1'b0;
    dm_rvalid   = 1'b0;
    memWidth    = 3'($urandom_range(0, 7));
    addr_E      = rnd64();
    writeData_E = rnd64();
    signedRead  = 1'($urandom_range(0, 1));
    dm_rdata    = rnd64();
  endtask

  // One access from presentation in IDLE until the FSM is back in IDLE
  task automatic run_op(input bit st, input bit both, input logic [2:0] w,
                        input logic [N-1:0] a, input logic [N-1:0] wd, input bit sg,
                        input int gd, input int rd, input int fmode, input int fat,
                        input logic [N-1:0] rdat);
    int c, i, j, outcome, off;
    bit killed;
    memWrite_E  = st;
    memRead_E   = !st || both;
    memWidth    = w;
    addr_E      = a;
    writeData_E = wd;
    signedRead  = sg;
    off         = m_off(a);
    if (fmode == F_IDLE) begin
      flush = 1'b1;
      tick();
      return;
    end
    if (m_bad(w, a, N)) begin
      nxt_mis = 1'b1;
      tick();
      return;
    end
    exp_stall = 1'b1;
    exp_we    = st;
    exp_addr  = a - N'(off);
    exp_be    = m_be(w, off);
    exp_wdata = m_wdata(wd, off);
    tick();
    c = 0; i = 0; killed = 1'b0;
    // request phase
    forever begin
      exp_req = 1'b1; exp_stall = 1'b1;
      outcome = 0;
      if (i == gd) begin
        dm_gnt = 1'b1; outcome = 1;
      end else begin
        if (fmode == F_REQ && i == fat) begin flush = 1'b1; outcome = 2; end
        if (TMO > 0 && c + 1 == TMO) begin nxt_berr = 1'b1; outcome = 2; end
      end
      c++; i++;
      tick();
      if (outcome != 0) break;
    end
    // response phase (loads only)
    if (outcome == 1 && !st) begin
      j = 0;
      forever begin
        exp_stall = 1'b1;
        if (fmode == F_RSP && j == fat) begin flush = 1'b1; killed = 1'b1; end
        if (j == rd) begin
          dm_rvalid = 1'b1;
          dm_rdata  = rdat;
          if (!killed) begin
            nxt_lv = 1'b1;
            exp_rd = m_load(rdat, w, off, sg);
          end
          outcome = 3;
        end else if (TMO > 0 && c + 1 == TMO) begin
          nxt_berr = 1'b1; outcome = 2;
        end
        c++; j++;
        tick();
        if (outcome != 1) break;
      end
    end
    // DONE: no stall and no new start, whatever the inputs do
    memRead_E = 1'($urandom_range(0, 1));
    flush     = 1'($urandom_range(0, 1));
    dm_gnt    = 1'($urandom_range(0, 1));
    dm_rvalid = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      dm_gnt    = 1'($urandom_range(0, 1));
      dm_rvalid = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit st, both, sg;
    logic [2:0] w;
    logic [N-1:0] a;
    int gd, rd, fm, fat;

    reset = 1'b1;
    memRead_E = 0; memWrite_E = 0; flush = 0; dm_gnt = 0; dm_rvalid = 0;
    memWidth = 0; addr_E = 0; writeData_E = 0; signedRead = 0; dm_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall_M, 1'b0);
    check("rst_req", dm_req, 1'b0);
    check("rst_be", dm_be, 8'h00);
    check("rst_lv", loadValid_M, 1'b0);
    check("rst_rd", readDataMasked_M, 64'h0);
    check("rst_mis", misaligned_M, 1'b0);
    check("rst_berr", busError_M, 1'b0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Pin the model to hand-computed values
    check("model_lw", m_load(64'h8000_0000_0000_0000, 3'b010, 4, 1'b1), 64'hFFFF_FFFF_8000_0000);
    check("model_lbu", m_load(64'hFF00_0000_0000_0000, 3'b000, 7, 1'b0), 64'h0000_0000_0000_00FF);
    check("model_sb_be", m_be(3'b000, 3), 8'h08);
    check("model_sb_wdata", m_wdata(64'hAB, 3), 64'h0000_0000_AB00_0000);
    check("model_lh_bad", m_bad(3'b001, 64'h11, 64), 1'b1);
    check("model_ld32_bad", m_bad(3'b011, 64'h0, 32), 1'b1);

    tick();
    // LW signed at 0x1004, minimum latency
    run_op(0, 0, 3'b010, 64'h1004, 64'h0, 1, 0, 0, F_NONE, 0, 64'h8000_0000_0000_0000);
    gap(2);
    check("lw_hold", readDataMasked_M, 64'hFFFF_FFFF_8000_0000);
    // SB at 0x2003
    run_op(1, 0, 3'b000, 64'h2003, 64'hAB, 0, 0, 0, F_NONE, 0, 64'h0);
    // LH at 0x11 misaligned, reserved width
    run_op(0, 0, 3'b001, 64'h11, 64'h0, 1, 0, 0, F_NONE, 0, 64'h0);
    run_op(0, 0, 3'b101, 64'h0, 64'h0, 0, 0, 0, F_NONE, 0, 64'h0);
    // LBU at 0x7, grant held off for 5 cycles
    run_op(0, 0, 3'b000, 64'h7, 64'h0, 0, 5, 0, F_NONE, 0, 64'hFF00_0000_0000_0000);
`ifndef LSU_TIMEOUT_EN
    check("lbu_hold", readDataMasked_M, 64'h0000_0000_0000_00FF);
`endif
    // Flush during RSP, data three cycles later
    run_op(0, 0, 3'b011, 64'h40, 64'h0, 0, 0, 3, F_RSP, 0, rnd64());
    // Both read and write set: store wins
    run_op(1, 1, 3'b001, 64'h3006, 64'h1234_5678, 0, 1, 0, F_NONE, 0, 64'h0);

    // Reset while in REQ abandons the access
    memRead_E = 1'b1; memWidth = 3'b010; addr_E = 64'h300; signedRead = 1'b0;
    exp_stall = 1'b1; exp_we = 1'b0; exp_addr = 64'h300; exp_be = m_be(3'b010, 0);
    tick();
    exp_req = 1'b1; exp_stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_drops_req", dm_req, 1'b0);
    repeat (3) begin
      dm_rvalid = 1'b1;
      tick();
    end

    // 32-bit datapath: LD is illegal, LH sign-extends
    m32_read = 1'b1; m32_width = 3'b011; m32_addr = 32'h0;
    #1 check("n32_ld_nostall", o32_stall, 1'b0);
    tick();
    m32_read = 1'b0;
    #1 check("n32_ld_mis", o32_mis, 1'b1);
    check("n32_ld_noreq", o32_req, 1'b0);
    m32_read = 1'b1; m32_width = 3'b001; m32_addr = 32'h102; m32_signed = 1'b1;
    #1 check("n32_lh_stall", o32_stall, 1'b1);
    tick();
    m32_read = 1'b0;
    #1 check("n32_lh_req", o32_req, 1'b1);
    check("n32_lh_addr", o32_addr, 32'h100);
    check("n32_lh_be", o32_be, 4'b1100);
    m32_gnt = 1'b1;
    tick();
    m32_gnt = 1'b0; m32_rvalid = 1'b1; m32_rdata = 32'h8001_1234;
    #1 check("n32_rsp_stall", o32_stall, 1'b1);
    tick();
    m32_rvalid = 1'b0;
    #1 check("n32_lv", o32_lv, 1'b1);
    check("n32_rd", o32_rd, 32'hFFFF_8001);
    check("n32_done_stall", o32_stall, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      st   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 3) == 0);
      sg   = 1'($urandom_range(0, 1));
      w    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a    = rnd64();
      if ($urandom_range(0, 3) != 0) a = a & ~((N'(1) << w[1:0]) - N'(1));
      gd   = $urandom_range(0, 4);
      rd   = $urandom_range(0, 4);
      fm   = $urandom_range(0, 7);
      fm   = (fm < 5) ? F_NONE : fm - 4;
      fat  = 0;
      if (fm == F_IDLE && m_bad(w, a, N)) fm = F_NONE;
      if (fm == F_REQ) begin
        if (gd == 0) fm = F_NONE;
        else fat = $urandom_range(0, gd - 1);
      end
      if (fm == F_RSP) begin
        if (st) fm = F_NONE;
        else fat = $urandom_range(0, rd);
      end
      run_op(st, both, w, a, rnd64(), sg, gd, rd, fm, fat, rnd64());
      gap($urandom_range(0, 2));
    end

    tick();
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
